// File: rtl/rgb_proc_pkg.sv
// Shared constants for the RGB/gray pixel processing blocks: luma weights,
// operating modes and the active-window pixel count.
package rgb_proc_pkg;

    localparam int unsigned LUMA_R = 54;
    localparam int unsigned LUMA_G = 183;
    localparam int unsigned LUMA_B = 18;

    typedef enum logic [1:0] {
        ModeBypass = 2'd0,
        ModeGray   = 2'd1,
        ModeAdapt  = 2'd2,
        ModeBinary = 2'd3
    } mode_e;

    function automatic int unsigned pixel_count(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/frame_mean_div.sv
// Sequential restoring divider: one quotient bit per cycle, constant divisor.
// A LOAD cycle with done=1 follows the last quotient bit.
module frame_mean_div
    import rgb_proc_pkg::*;
#(
    parameter int unsigned ACC_W   = 27,
    parameter int unsigned DIVISOR = 294926
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] quotient
);

    typedef enum logic [1:0] {StIdle, StDiv, StLoad} div_state_e;

    localparam int unsigned CNT_W = $clog2(ACC_W) + 1;
    localparam int unsigned RW    = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(ACC_W - 1);
    localparam logic [RW-1:0]    DIVISOR_EXT = RW'(DIVISOR);

    div_state_e       state_q, state_d;
    logic [ACC_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    rem_shift;

    // quo_q starts as the dividend and is shifted out MSB-first while the
    // quotient bits are shifted in at the LSB.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        busy      = (state_q != StIdle);
        rem_shift = {rem_q, quo_q[ACC_W-1]};
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = dividend;
                    cnt_d   = '0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                if (rem_shift >= DIVISOR_EXT) begin
                    rem_d = ACC_W'(rem_shift - DIVISOR_EXT);
                    quo_d = {quo_q[ACC_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[ACC_W-1:0];
                    quo_d = {quo_q[ACC_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/rgb_gray_adapt.sv
// Three-stage RGB-to-gray pipeline with bypass, gray, mean-adaptive gain and
// binary threshold modes; the threshold is the previous frame's mean luma.
module rgb_gray_adapt
    import rgb_proc_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned POS_W    = 13,
    parameter int unsigned ACT_ROWS = 478,
    parameter int unsigned ACT_COLS = 617,
    parameter int unsigned GAIN_W   = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iVALID,
    input  logic [DATA_W-1:0] iR,
    input  logic [DATA_W-1:0] iG,
    input  logic [DATA_W-1:0] iB,
    input  logic [POS_W-1:0]  iROW,
    input  logic [POS_W-1:0]  iCOL,
    input  logic [1:0]        iMODE,
    input  logic [GAIN_W-1:0] iGAIN,
    output logic              oVALID,
    output logic [DATA_W-1:0] oR,
    output logic [DATA_W-1:0] oG,
    output logic [DATA_W-1:0] oB,
    output logic [DATA_W-1:0] oMEAN,
    output logic              oMEAN_VALID,
    output logic              oOVERRUN
);

    localparam int unsigned NPIX  = pixel_count(ACT_ROWS, ACT_COLS);
    localparam int unsigned ACC_W = DATA_W + $clog2(NPIX);
    localparam int unsigned LW    = DATA_W + 10;
    localparam int unsigned MW    = DATA_W + ((GAIN_W > 4) ? GAIN_W : 4) + 2;

    localparam logic [DATA_W-1:0] PIX_MAX  = '1;
    localparam logic [DATA_W-1:0] MEAN_RST = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [POS_W-1:0]  ROW_LIM  = POS_W'(ACT_ROWS);
    localparam logic [POS_W-1:0]  COL_LIM  = POS_W'(ACT_COLS);
    localparam logic [POS_W-1:0]  ROW_LAST = POS_W'(ACT_ROWS - 1);
    localparam logic [POS_W-1:0]  COL_LAST = POS_W'(ACT_COLS - 1);

    logic [LW-1:0]     luma_sum;
    logic [DATA_W-1:0] y_in;
    logic              in_win;
    logic              frame_end;
    logic [ACC_W-1:0]  acc_q, acc_sum;

    logic              div_start, div_busy, div_done;
    logic [ACC_W-1:0]  div_quo;
    logic [DATA_W-1:0] mean_q;
    logic              mean_valid_q, overrun_q;

    logic              v1_q, win1_q, v2_q, win2_q, gt2_q;
    mode_e             mode1_q, mode2_q;
    logic [GAIN_W-1:0] gain1_q, gain2_q;
    logic [DATA_W-1:0] r1_q, g1_q, b1_q, y1_q;
    logic [DATA_W-1:0] r2_q, g2_q, b2_q, y2_q;

    logic [MW-1:0]     bright_full, dark_full, dark_gain;
    logic [DATA_W-1:0] adapt_pix;
    logic [DATA_W-1:0] r_d, g_d, b_d;
    logic              ov_q;
    logic [DATA_W-1:0] or_q, og_q, ob_q;

    assign luma_sum = LW'(LUMA_R) * LW'(iR) + LW'(LUMA_G) * LW'(iG) + LW'(LUMA_B) * LW'(iB);
    assign y_in     = DATA_W'(luma_sum >> 8);

    assign in_win    = (iROW < ROW_LIM) && (iCOL < COL_LIM);
    assign frame_end = iVALID && (iROW == ROW_LAST) && (iCOL == COL_LAST);
    assign acc_sum   = acc_q + ACC_W'(y_in);
    // A frame end while the divider is busy drops that frame's sum.
    assign div_start = frame_end && !div_busy;

    frame_mean_div #(
        .ACC_W   (ACC_W),
        .DIVISOR (NPIX)
    ) u_div (
        .clk      (iCLK),
        .rst      (iRST),
        .start    (div_start),
        .dividend (acc_sum),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            acc_q        <= '0;
            mean_q       <= MEAN_RST;
            mean_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (frame_end) begin
                acc_q <= '0;
            end else if (iVALID && in_win) begin
                acc_q <= acc_sum;
            end
            if (div_done) begin
                mean_q <= DATA_W'(div_quo);
            end
            mean_valid_q <= div_done;
            overrun_q    <= frame_end && div_busy;
        end
    end

    if (GAIN_W > 4) begin : g_gain_clamp
        assign dark_gain = (MW'(gain2_q) > MW'(15)) ? MW'(15) : MW'(gain2_q);
    end else begin : g_gain_pass
        assign dark_gain = MW'(gain2_q);
    end

    always_comb begin
        bright_full = (MW'(y2_q) * (MW'(16) + MW'(gain2_q))) >> 4;
        dark_full   = (MW'(y2_q) * (MW'(16) - dark_gain)) >> 4;
        if (gt2_q) begin
            adapt_pix = (bright_full > MW'(PIX_MAX)) ? PIX_MAX : DATA_W'(bright_full);
        end else begin
            adapt_pix = DATA_W'(dark_full);
        end
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (v2_q && win2_q) begin
            unique case (mode2_q)
                ModeBypass: begin
                    r_d = r2_q;
                    g_d = g2_q;
                    b_d = b2_q;
                end
                ModeGray: begin
                    r_d = y2_q;
                    g_d = y2_q;
                    b_d = y2_q;
                end
                ModeAdapt: begin
                    r_d = adapt_pix;
                    g_d = adapt_pix;
                    b_d = adapt_pix;
                end
                ModeBinary: begin
                    r_d = gt2_q ? PIX_MAX : '0;
                    g_d = gt2_q ? PIX_MAX : '0;
                    b_d = gt2_q ? PIX_MAX : '0;
                end
                default: ;
            endcase
        end
    end

    // The mean comparison happens between stages 1 and 2, so a freshly
    // loaded mean applies to the pixel sitting in stage 1 that cycle.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v1_q    <= 1'b0;
            win1_q  <= 1'b0;
            mode1_q <= ModeBypass;
            gain1_q <= '0;
            r1_q    <= '0;
            g1_q    <= '0;
            b1_q    <= '0;
            y1_q    <= '0;
            v2_q    <= 1'b0;
            win2_q  <= 1'b0;
            gt2_q   <= 1'b0;
            mode2_q <= ModeBypass;
            gain2_q <= '0;
            r2_q    <= '0;
            g2_q    <= '0;
            b2_q    <= '0;
            y2_q    <= '0;
            ov_q    <= 1'b0;
            or_q    <= '0;
            og_q    <= '0;
            ob_q    <= '0;
        end else begin
            v1_q    <= iVALID;
            win1_q  <= in_win;
            mode1_q <= mode_e'(iMODE);
            gain1_q <= iGAIN;
            r1_q    <= iR;
            g1_q    <= iG;
            b1_q    <= iB;
            y1_q    <= y_in;
            v2_q    <= v1_q;
            win2_q  <= win1_q;
            gt2_q   <= (y1_q > mean_q);
            mode2_q <= mode1_q;
            gain2_q <= gain1_q;
            r2_q    <= r1_q;
            g2_q    <= g1_q;
            b2_q    <= b1_q;
            y2_q    <= y1_q;
            ov_q    <= v2_q;
            or_q    <= r_d;
            og_q    <= g_d;
            ob_q    <= b_d;
        end
    end

    assign oVALID      = ov_q;
    assign oR          = or_q;
    assign oG          = og_q;
    assign oB          = ob_q;
    assign oMEAN       = mean_q;
    assign oMEAN_VALID = mean_valid_q;
    assign oOVERRUN    = overrun_q;

endmodule
